// File: rtl/jtkcpu_busctrl_pkg.sv
// jtkcpu_busctrl_pkg: bus sequencer state encoding and vector offsets.
// Shared by jtkcpu_busctrl and jtkcpu_busctrl_shift.
package jtkcpu_busctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_VEC  = 2'd3
  } state_e;

  localparam int VOFS_IRQ  = 6;
  localparam int VOFS_FIRQ = 8;
  localparam int VOFS_NMI  = 2;
  localparam int VEC_BYTES = 2;

  function automatic logic [2:0] eff_len(
    input logic [2:0] len,
    input int         maxb
  );
    if (len == 3'd0 || int'(len) > maxb) return 3'd1;
    return len;
  endfunction

endpackage

// File: rtl/jtkcpu_busctrl_shift.sv
// jtkcpu_busctrl_shift: byte counter plus read/write shift registers.
// Write data is left-aligned on load so the top byte is always next out.
module jtkcpu_busctrl_shift
  import jtkcpu_busctrl_pkg::*;
#(
  parameter int MAXB = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_i,
  input  logic              ld_rd_i,
  input  logic              step_i,
  input  logic              sh_rd_i,
  input  logic [2:0]        len_i,
  input  logic [8*MAXB-1:0] wdata_i,
  input  logic [7:0]        din_i,
  output logic              first_o,
  output logic              last_o,
  output logic [7:0]        msb_o,
  output logic [7:0]        nbyte_o,
  output logic [8*MAXB-1:0] rdata_o
);

  localparam int DW = 8 * MAXB;

  logic [2:0]    cnt_q;
  logic          first_q;
  logic [DW-1:0] wsh_q;
  logic [DW-1:0] rd_q;
  logic [DW-1:0] wal;
  logic [5:0]    wsh_amt;

  assign wsh_amt = {3'(MAXB) - len_i, 3'b000};
  assign wal     = wdata_i << wsh_amt;
  assign msb_o   = wal[DW-1 -: 8];
  assign nbyte_o = wsh_q[DW-1 -: 8];
  assign last_o  = (cnt_q == 3'd1);
  assign first_o = first_q;
  assign rdata_o = rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 3'd0;
      first_q <= 1'b0;
      wsh_q   <= '0;
      rd_q    <= '0;
    end else if (ld_i) begin
      cnt_q   <= len_i;
      first_q <= 1'b1;
      wsh_q   <= wal << 8;
      if (ld_rd_i) rd_q <= '0;
    end else if (step_i) begin
      cnt_q   <= cnt_q - 3'd1;
      first_q <= 1'b0;
      wsh_q   <= wsh_q << 8;
      if (sh_rd_i) rd_q <= (rd_q << 8) | DW'(din_i);
    end
  end

endmodule

// File: rtl/jtkcpu_busctrl.sv
// jtkcpu_busctrl: splits KCPU requests into big-endian byte cycles.
// Define JTKCPU_WAITST_EN to let bus_ok stall byte cycles.
module jtkcpu_busctrl
  import jtkcpu_busctrl_pkg::*;
#(
  parameter int            AW     = 16,
  parameter int            MAXB   = 2,
  parameter logic [AW-1:0] RSTVEC = AW'(16'hFFFE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              halt,
  input  logic              req,
  input  logic              req_we,
  input  logic              req_op,
  input  logic [2:0]        req_len,
  input  logic [AW-1:0]     req_addr,
  input  logic [8*MAXB-1:0] req_wdata,
  input  logic [3:0]        intvec,
  input  logic              bus_ok,
  input  logic [7:0]        din,
  output logic [AW-1:0]     addr,
  output logic [7:0]        dout,
  output logic              we,
  output logic              ack,
  output logic              done,
  output logic [8*MAXB-1:0] rdata,
  output logic [7:0]        op,
  output logic              is_op,
  output logic [15:0]       vec_pc,
  output logic              vec_ok,
  output logic              busy
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    dout_q, dout_d;
  logic          we_q, we_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          vok_q, vok_d;
  logic [7:0]    op_q, op_d;
  logic          isop_q, isop_d;
  logic [15:0]   vpc_q, vpc_d;
  logic [7:0]    vhi_q, vhi_d;

  logic          ok, adv, bstep;
  logic          ld, ld_rd, step;
  logic [2:0]    ld_len;
  logic          first, last;
  logic [7:0]    msb, nbyte;
  logic [AW-1:0] vec_a;

`ifdef JTKCPU_WAITST_EN
  assign ok = bus_ok;
`else
  logic unused_bus_ok;
  assign unused_bus_ok = bus_ok;
  assign ok = 1'b1;
`endif

  assign adv   = cen & ~halt;
  assign bstep = adv & ok;

  always_comb begin
    vec_a = RSTVEC - AW'(VOFS_IRQ);
    priority case (1'b1)
      intvec[3]: vec_a = RSTVEC;
      intvec[2]: vec_a = RSTVEC - AW'(VOFS_NMI);
      intvec[1]: vec_a = RSTVEC - AW'(VOFS_FIRQ);
      default:   vec_a = RSTVEC - AW'(VOFS_IRQ);
    endcase
  end

  // pulses hold their value only while halted
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    we_d    = we_q;
    op_d    = op_q;
    isop_d  = isop_q;
    vpc_d   = vpc_q;
    vhi_d   = vhi_q;
    ack_d   = halt & ack_q;
    done_d  = halt & done_q;
    vok_d   = halt & vok_q;
    ld      = 1'b0;
    ld_rd   = 1'b0;
    step    = 1'b0;
    ld_len  = eff_len(req_len, MAXB);
    unique case (state_q)
      ST_IDLE: begin
        if (adv && intvec != 4'd0) begin
          ld      = 1'b1;
          ld_len  = 3'(VEC_BYTES);
          addr_d  = vec_a;
          state_d = ST_VEC;
        end else if (adv && req) begin
          ld     = 1'b1;
          ack_d  = 1'b1;
          addr_d = req_addr;
          if (req_we) begin
            dout_d  = msb;
            we_d    = 1'b1;
            state_d = ST_WR;
          end else begin
            ld_rd   = 1'b1;
            isop_d  = req_op;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (bstep) begin
          step = 1'b1;
          if (first && isop_q) op_d = din;
          if (last) begin
            done_d  = 1'b1;
            isop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_WR: begin
        if (bstep) begin
          step = 1'b1;
          if (last) begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            dout_d = nbyte;
            addr_d = addr_q + AW'(1);
          end
        end
      end
      ST_VEC: begin
        if (bstep) begin
          step = 1'b1;
          if (last) begin
            vpc_d   = {vhi_q, din};
            vok_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            vhi_d  = din;
            addr_d = addr_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= RSTVEC;
      dout_q  <= 8'd0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      vok_q   <= 1'b0;
      op_q    <= 8'd0;
      isop_q  <= 1'b0;
      vpc_q   <= 16'd0;
      vhi_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      vok_q   <= vok_d;
      op_q    <= op_d;
      isop_q  <= isop_d;
      vpc_q   <= vpc_d;
      vhi_q   <= vhi_d;
    end
  end

  jtkcpu_busctrl_shift #(
    .MAXB (MAXB)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (ld),
    .ld_rd_i (ld_rd),
    .step_i  (step),
    .sh_rd_i (state_q == ST_RD),
    .len_i   (ld_len),
    .wdata_i (req_wdata),
    .din_i   (din),
    .first_o (first),
    .last_o  (last),
    .msb_o   (msb),
    .nbyte_o (nbyte),
    .rdata_o (rdata)
  );

  assign addr   = addr_q;
  assign dout   = dout_q;
  assign we     = we_q;
  assign ack    = ack_q;
  assign done   = done_q;
  assign vec_ok = vok_q;
  assign op     = op_q;
  assign is_op  = isop_q;
  assign vec_pc = vpc_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
